// File: rtl/pool_frame_sequencer_if.sv
// Coordinate/enable bus between the frame sequencer (master) and the 2x2 max-pool datapath (slave).
interface pool_frame_sequencer_if #(
  parameter int H_BITW = 7,
  parameter int V_BITW = 6
);
  logic              dp_enable;
  logic [H_BITW-1:0] dp_hcnt;
  logic [V_BITW-1:0] dp_vcnt;
  logic              pool_valid;

  modport master (
    output dp_enable,
    output dp_hcnt,
    output dp_vcnt,
    input  pool_valid
  );

  modport slave (
    input  dp_enable,
    input  dp_hcnt,
    input  dp_vcnt,
    output pool_valid
  );
endinterface

// File: rtl/pool_frame_sequencer.sv
// Frame-level controller for a 2x2 max-pool stage: raster coordinate generation, end-of-frame
// pipeline drain, pooled-output counting and per-frame done / count-mismatch reporting.
module pool_frame_sequencer #(
  parameter int WIDTH    = 64,
  parameter int HEIGHT   = 48,
  parameter int W_WIDTH  = 80,
  parameter int W_HEIGHT = 52,
  parameter int LEVEL    = 0,
  parameter int DRAIN    = 8
) (
  input  logic                                          clock,
  input  logic                                          n_rst,
  input  logic                                          start,
  input  logic                                          cont,
  input  logic                                          abort,
  pool_frame_sequencer_if.master                        dp,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          err,
  output logic [$clog2(W_WIDTH)+$clog2(W_HEIGHT)-1:0]   pool_count
);

  localparam int H_BITW   = $clog2(W_WIDTH);
  localparam int V_BITW   = $clog2(W_HEIGHT);
  localparam int CNT_BITW = H_BITW + V_BITW;

  localparam logic [H_BITW-1:0]   H_LAST     = H_BITW'(W_WIDTH - 1);
  localparam logic [V_BITW-1:0]   V_LAST     = V_BITW'(W_HEIGHT - 1);
  localparam logic [CNT_BITW-1:0] EXPECTED   =
    CNT_BITW'((W_HEIGHT >> (LEVEL + 1)) * (W_WIDTH >> (LEVEL + 1)));
  localparam logic [7:0]          DRAIN_LOAD = 8'(DRAIN - 1);

  if (WIDTH > W_WIDTH || HEIGHT > W_HEIGHT || DRAIN < 1 || DRAIN > 255) begin : g_param_check
    $error("pool_frame_sequencer: active size exceeds frame or DRAIN outside 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [H_BITW-1:0]   hcnt_q, hcnt_d;
  logic [V_BITW-1:0]   vcnt_q, vcnt_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_BITW-1:0] count_q, count_d;
  logic [7:0]          drain_q, drain_d;
  logic                ovl_q, ovl_d;

  logic [CNT_BITW-1:0] count_inc;
  logic                last_pix;
  logic                tail_active;

  assign count_inc   = (busy_q && dp.pool_valid && (count_q != '1)) ? count_q + 1'b1 : count_q;
  assign last_pix    = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  // The drain counter serves both the DRAIN state and a previous frame overlapping a back-to-back RUN.
  assign tail_active = (state_q == S_DRAIN) || ovl_q;

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    count_d = count_inc;
    drain_d = drain_q;
    ovl_d   = ovl_q;

    if (tail_active) begin
      if (drain_q != 8'd0) begin
        drain_d = drain_q - 8'd1;
        done_d  = (drain_q == 8'd1);
      end else begin
        err_d = err_q | (count_inc != EXPECTED);
        ovl_d = 1'b0;
        if (ovl_q) begin
          count_d = '0;
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          hcnt_d  = '0;
          vcnt_d  = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          count_d = '0;
          err_d   = 1'b0;
          ovl_d   = 1'b0;
        end
      end

      S_RUN: begin
        if (hcnt_q == H_LAST) begin
          hcnt_d = '0;
          vcnt_d = vcnt_q + 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
        if (last_pix) begin
          hcnt_d  = '0;
          vcnt_d  = '0;
          drain_d = DRAIN_LOAD;
          done_d  = (DRAIN_LOAD == 8'd0);
          if (cont && start) begin
            ovl_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (drain_q == 8'd0) begin
          state_d = S_IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Abort drops the frame without a completion: err and pool_count keep their values.
    if (abort) begin
      state_d = S_IDLE;
      hcnt_d  = '0;
      vcnt_d  = '0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      count_d = count_q;
      drain_d = 8'd0;
      ovl_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      drain_q <= 8'd0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
      drain_q <= drain_d;
      ovl_q   <= ovl_d;
    end
  end

  assign dp.dp_enable = en_q;
  assign dp.dp_hcnt   = hcnt_q;
  assign dp.dp_vcnt   = vcnt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign pool_count   = count_q;

endmodule
